// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with frame-synchronous display value
// Counters, sync decodes and strobes all change on the same clk edge.
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    output logic        pixel_tick,
    output logic [9:0]  hcount,
    output logic [9:0]  vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] value_frame
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [4:0] DIV_LAST = 5'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic       SYNC_ACT = (SYNC_POL != 0);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_params
            $error("vga_timing_gen: illegal timing parameters");
        end
    endgenerate

    logic [4:0]  r_div;
    logic [9:0]  r_hcount;
    logic [9:0]  r_vcount;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_video_on;
    logic        r_line_start;
    logic        r_frame_start;
    logic        r_first_tick;
    logic [15:0] r_value_frame;

    logic        w_tick;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic [9:0]  w_h_next;
    logic [9:0]  w_v_next;

    // Gated by rst so the tick reads 0 while held in reset, even with CLK_DIV = 1.
    assign w_tick   = (r_div == DIV_LAST) && !rst;
    assign w_h_wrap = (r_hcount == H_LAST);
    assign w_v_wrap = (r_vcount == V_LAST);

    always_comb begin
        w_h_next = r_hcount;
        w_v_next = r_vcount;
        if (w_tick) begin
            if (w_h_wrap) begin
                w_h_next = '0;
                w_v_next = w_v_wrap ? '0 : r_vcount + 10'd1;
            end else begin
                w_h_next = r_hcount + 10'd1;
            end
        end
    end

    // Decodes use the next counter values so they line up with hcount/vcount.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div         <= '0;
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= ~SYNC_ACT;
            r_vsync       <= ~SYNC_ACT;
            r_video_on    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_first_tick  <= 1'b1;
            r_value_frame <= '0;
        end else begin
            r_div         <= w_tick ? '0 : r_div + 5'd1;
            r_hcount      <= w_h_next;
            r_vcount      <= w_v_next;
            r_hsync       <= (w_h_next >= HS_FIRST && w_h_next <= HS_LAST) ? SYNC_ACT : ~SYNC_ACT;
            r_vsync       <= (w_v_next >= VS_FIRST && w_v_next <= VS_LAST) ? SYNC_ACT : ~SYNC_ACT;
            r_video_on    <= (w_h_next < H_VIS) && (w_v_next < V_VIS);
            r_line_start  <= w_tick && w_h_wrap;
            r_frame_start <= w_tick && w_h_wrap && w_v_wrap;
            if (w_tick) begin
                r_first_tick <= 1'b0;
                if (r_first_tick || (w_h_wrap && w_v_wrap)) begin
                    r_value_frame <= value_in;
                end
            end
        end
    end

    assign pixel_tick  = w_tick;
    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign value_frame = r_value_frame;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
// Three instances: default, CLK_DIV=1, and a small positive-sync raster.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_in = 16'h0000;

    int checks = 0;
    int errors = 0;

    logic        d4_tick, d4_hs, d4_vs, d4_von, d4_ls, d4_fs;
    logic [9:0]  d4_h, d4_v;
    logic [15:0] d4_vf;
    logic        d1_tick, d1_hs, d1_vs, d1_von, d1_ls, d1_fs;
    logic [9:0]  d1_h, d1_v;
    logic [15:0] d1_vf;
    logic        sm_tick, sm_hs, sm_vs, sm_von, sm_ls, sm_fs;
    logic [9:0]  sm_h, sm_v;
    logic [15:0] sm_vf;

    always #5 clk = ~clk;

    vga_timing_gen u_d4 (
        .clk(clk), .rst(rst), .value_in(value_in),
        .pixel_tick(d4_tick), .hcount(d4_h), .vcount(d4_v),
        .hsync(d4_hs), .vsync(d4_vs), .video_on(d4_von),
        .line_start(d4_ls), .frame_start(d4_fs), .value_frame(d4_vf)
    );

    vga_timing_gen #(.CLK_DIV(1)) u_d1 (
        .clk(clk), .rst(rst), .value_in(value_in),
        .pixel_tick(d1_tick), .hcount(d1_h), .vcount(d1_v),
        .hsync(d1_hs), .vsync(d1_vs), .video_on(d1_von),
        .line_start(d1_ls), .frame_start(d1_fs), .value_frame(d1_vf)
    );

    // 15 x 8 raster: hsync at h 10..12, vsync at v 5..6, visible 8 x 4.
    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1)
    ) u_sm (
        .clk(clk), .rst(rst), .value_in(value_in),
        .pixel_tick(sm_tick), .hcount(sm_h), .vcount(sm_v),
        .hsync(sm_hs), .vsync(sm_vs), .video_on(sm_von),
        .line_start(sm_ls), .frame_start(sm_fs), .value_frame(sm_vf)
    );

    task automatic reset_release();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [41:0] exp4, expsm;
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp4  = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        expsm = {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        checks++;
        if ({d4_tick, d4_h, d4_v, d4_hs, d4_vs, d4_von, d4_ls, d4_fs, d4_vf} !== exp4) begin
            errors++;
            $display("FAIL reset_default got %h exp %h",
                     {d4_tick, d4_h, d4_v, d4_hs, d4_vs, d4_von, d4_ls, d4_fs, d4_vf}, exp4);
        end
        checks++;
        if ({d1_tick, d1_h, d1_v, d1_hs, d1_vs, d1_von, d1_ls, d1_fs, d1_vf} !== exp4) begin
            errors++;
            $display("FAIL reset_div1 got %h exp %h",
                     {d1_tick, d1_h, d1_v, d1_hs, d1_vs, d1_von, d1_ls, d1_fs, d1_vf}, exp4);
        end
        checks++;
        if ({sm_tick, sm_h, sm_v, sm_hs, sm_vs, sm_von, sm_ls, sm_fs, sm_vf} !== expsm) begin
            errors++;
            $display("FAIL reset_small_pospol got %h exp %h",
                     {sm_tick, sm_h, sm_v, sm_hs, sm_vs, sm_von, sm_ls, sm_fs, sm_vf}, expsm);
        end
    endtask

    task automatic test_divider();
        value_in = 16'h0000;
        reset_release();
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if (d4_tick !== ((k % 4) == 0)) begin
                errors++;
                $display("FAIL div_tick cycle %0d got %b exp %b", k, d4_tick, ((k % 4) == 0));
            end
            checks++;
            if (d4_h !== 10'((k - 1) / 4)) begin
                errors++;
                $display("FAIL div_hcount cycle %0d got %0d exp %0d", k, d4_h, (k - 1) / 4);
            end
            checks++;
            if ({d4_hs, d4_vs} !== 2'b11) begin
                errors++;
                $display("FAIL div_sync_idle cycle %0d got %b exp 11", k, {d4_hs, d4_vs});
            end
            checks++;
            if ({d1_tick, d1_h} !== {1'b1, 10'(k - 1)}) begin
                errors++;
                $display("FAIL div1_tick_hcount cycle %0d got %b/%0d exp 1/%0d", k, d1_tick, d1_h, k - 1);
            end
            next_cycle();
        end
    endtask

    task automatic test_line();
        int ls_count = 0;
        logic [14:0] exp, got;
        int h, v;
        reset_release();
        for (int k = 1; k <= 805; k++) begin
            h = (k - 1) % 800;
            v = (k - 1) / 800;
            exp = {10'(h), !(h >= 656 && h <= 751), 1'b1,
                   (k > 1) && (h < 640) && (v < 480), (k == 801), 1'b0};
            got = {d1_h, d1_hs, d1_vs, d1_von, d1_ls, d1_fs};
            checks++;
            if (got !== exp || d1_v !== 10'(v)) begin
                errors++;
                $display("FAIL line_sweep cycle %0d got h%0d v%0d %b exp h%0d v%0d %b",
                         k, d1_h, d1_v, got[4:0], h, v, exp[4:0]);
            end
            if (d1_ls) ls_count++;
            next_cycle();
        end
        checks++;
        if (ls_count !== 1) begin
            errors++;
            $display("FAIL line_start_count got %0d exp 1", ls_count);
        end
    endtask

    task automatic test_frame();
        int von_count = 0, vs_count = 0, fs_count = 0;
        int t, h, v;
        logic [24:0] exp, got;
        reset_release();
        for (int k = 1; k <= 245; k++) begin
            t = k - 1;
            h = t % 15;
            v = (t / 15) % 8;
            exp = {10'(h), 10'(v), (h >= 10 && h <= 12), (v >= 5 && v <= 6),
                   (t > 0) && (h < 8) && (v < 4), (t > 0) && (h == 0),
                   (t > 0) && (h == 0) && (v == 0)};
            got = {sm_h, sm_v, sm_hs, sm_vs, sm_von, sm_ls, sm_fs};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL frame_sweep cycle %0d got %h exp %h", k, got, exp);
            end
            if (t >= 120 && t < 240) begin
                if (sm_von) von_count++;
                if (sm_vs) vs_count++;
                if (sm_fs) fs_count++;
            end
            next_cycle();
        end
        checks++;
        if (von_count !== 32) begin
            errors++;
            $display("FAIL video_on_count got %0d exp 32", von_count);
        end
        checks++;
        if (vs_count !== 30) begin
            errors++;
            $display("FAIL vsync_count got %0d exp 30", vs_count);
        end
        checks++;
        if (fs_count !== 1) begin
            errors++;
            $display("FAIL frame_start_count got %0d exp 1", fs_count);
        end
    endtask

    task automatic test_value_frame();
        value_in = 16'h00A3;
        reset_release();
        checks++;
        if (sm_vf !== 16'h0000) begin
            errors++;
            $display("FAIL vf_before_tick got %h exp 0000", sm_vf);
        end
        next_cycle();
        checks++;
        if (sm_vf !== 16'h00A3) begin
            errors++;
            $display("FAIL vf_first_tick got %h exp 00a3", sm_vf);
        end
        next_cycle();
        next_cycle();
        checks++;
        if (d4_vf !== 16'h0000) begin
            errors++;
            $display("FAIL vf_div4_cycle4 got %h exp 0000", d4_vf);
        end
        next_cycle();
        checks++;
        if (d4_vf !== 16'h00A3) begin
            errors++;
            $display("FAIL vf_div4_cycle5 got %h exp 00a3", d4_vf);
        end
        for (int k = 6; k <= 18; k++) next_cycle();
        checks++;
        if ({sm_h, sm_v} !== {10'd2, 10'd1}) begin
            errors++;
            $display("FAIL vf_position got (%0d,%0d) exp (2,1)", sm_h, sm_v);
        end
        value_in = 16'h1234;
        for (int k = 19; k <= 120; k++) begin
            next_cycle();
            checks++;
            if (sm_vf !== 16'h00A3) begin
                errors++;
                $display("FAIL vf_hold cycle %0d got %h exp 00a3", k, sm_vf);
            end
        end
        next_cycle();
        checks++;
        if ({sm_fs, sm_vf} !== {1'b1, 16'h1234}) begin
            errors++;
            $display("FAIL vf_frame_load got fs%b %h exp fs1 1234", sm_fs, sm_vf);
        end
        checks++;
        if (d4_vf !== 16'h00A3) begin
            errors++;
            $display("FAIL vf_div4_hold got %h exp 00a3", d4_vf);
        end
    endtask

    task automatic test_reset_mid();
        logic [41:0] expsm;
        value_in = 16'h0077;
        reset_release();
        for (int k = 2; k <= 51; k++) next_cycle();
        checks++;
        if ({sm_h, sm_v, sm_vf} !== {10'd5, 10'd3, 16'h0077}) begin
            errors++;
            $display("FAIL mid_position got (%0d,%0d) %h exp (5,3) 0077", sm_h, sm_v, sm_vf);
        end
        value_in = 16'h5A5A;
        #1;
        rst = 1'b1;
        #1;
        expsm = {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        checks++;
        if ({sm_tick, sm_h, sm_v, sm_hs, sm_vs, sm_von, sm_ls, sm_fs, sm_vf} !== expsm) begin
            errors++;
            $display("FAIL mid_async_reset got %h exp %h",
                     {sm_tick, sm_h, sm_v, sm_hs, sm_vs, sm_von, sm_ls, sm_fs, sm_vf}, expsm);
        end
        checks++;
        if ({d4_h, d4_hs, d4_vs} !== {10'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL mid_async_reset_div4 got %0d %b%b exp 0 11", d4_h, d4_hs, d4_vs);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({sm_tick, sm_h, sm_v, sm_ls, sm_fs, sm_vf} !== {1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL mid_restart_cycle1 got %h exp %h",
                     {sm_tick, sm_h, sm_v, sm_ls, sm_fs, sm_vf},
                     {1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 16'h0000});
        end
        next_cycle();
        checks++;
        if ({sm_h, sm_v, sm_ls, sm_fs, sm_vf} !== {10'd1, 10'd0, 1'b0, 1'b0, 16'h5A5A}) begin
            errors++;
            $display("FAIL mid_restart_cycle2 got %h exp %h",
                     {sm_h, sm_v, sm_ls, sm_fs, sm_vf}, {10'd1, 10'd0, 1'b0, 1'b0, 16'h5A5A});
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_line();
        test_frame();
        test_value_frame();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the system clock: pixel tick, hcount/vcount, hsync/vsync, video_on, and line/frame strobes.
- Sits directly upstream of the digit glyph renderers. They compare hcount/vcount against fixed glyph windows to produce per-pixel hit.
- Holds a frame-synchronous copy of the displayed datapath value, so a digit's value never changes mid-frame (no tearing).

Parameters:
- CLK_DIV, 4: system clocks per pixel; 100 MHz / 4 = 25 MHz. Legal range 1..16.
- H_VISIBLE, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_VISIBLE, 480: visible lines per frame.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BACK, 33: vertical back porch, in lines.
- SYNC_POL, 0: sync active level; 0 = active-low.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- value_in  in  16  live datapath value to display.
- pixel_tick  out  1  one-clk pulse per pixel period.
- hcount  out  10  horizontal pixel position, 0..H_TOTAL-1.
- vcount  out  10  vertical line position, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync, at SYNC_POL level while asserted.
- vsync  out  1  vertical sync, at SYNC_POL level while asserted.
- video_on  out  1  high while (hcount, vcount) is inside the visible area.
- line_start  out  1  one-clk pulse when hcount becomes 0.
- frame_start  out  1  one-clk pulse when (hcount, vcount) becomes (0,0).
- value_frame  out  16  value_in sampled at frame boundary; feeds renderer num inputs.

Behaviour:
- Derived constants:
  - H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800).
  - V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
  - Elaboration error if H_TOTAL > 1024, V_TOTAL > 1024, or CLK_DIV < 1.
- Reset (async, immediate):
  - div counter = 0; hcount = 0; vcount = 0; value_frame = 0.
  - pixel_tick, line_start, frame_start, video_on = 0.
  - hsync = vsync = ~SYNC_POL (inactive).
  - first_tick flag = 1.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pixel_tick = (div == CLK_DIV-1), decoded combinationally from the register.
  - CLK_DIV = 1: pixel_tick is constantly 1 out of reset.
  - After rst deasserts, the first pixel_tick is high in clk cycle CLK_DIV.
- Counters, advanced only on a clk edge where pixel_tick = 1:
  - hcount = H_TOTAL-1 → hcount = 0 and vcount increments.
  - vcount = V_TOTAL-1 at the same time → vcount = 0.
  - No other wrap values; counters hold between ticks.
- Registered decodes, computed from the next counter values so they change on the same edge as hcount/vcount (zero skew):
  - hsync asserted while hcount in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = 656..751.
  - vsync asserted while vcount in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] = 490..491.
  - video_on = (hcount < H_VISIBLE) && (vcount < V_VISIBLE).
- Strobes, each high exactly one clk, in the cycle after the updating edge:
  - line_start: counters have just moved to hcount = 0.
  - frame_start: counters have just moved to (0,0).
  - Neither strobe is asserted by reset itself.
- value_frame:
  - Loads value_in on the edge where counters move to (0,0).
  - Also loads on the first pixel_tick edge after reset, then first_tick clears.
  - Otherwise holds; value_in changes mid-frame are invisible until the next frame_start.
- Reset mid-frame: everything returns to reset state at once; the raster restarts from (0,0) with no partial strobes.

Test Plan:
- Default params, release rst: pixel_tick high at clk cycles 4, 8, 12…; hcount = 1 after cycle 4; hsync/vsync = 1 during reset and afterwards.
- CLK_DIV=1 (all other params default), run 800 ticks:
  - hsync = 0 exactly while hcount is 656..751.
  - video_on falls when hcount becomes 640.
  - line_start pulses once, when hcount wraps to 0 and vcount becomes 1.
- CLK_DIV=1, run 420000 ticks:
  - vsync = 0 only while vcount is 490..491 (1600 ticks).
  - frame_start pulses exactly once, at the (524,799) → (0,0) transition.
  - video_on is high for exactly 307200 ticks per frame.
- value_in = 0x00A3 at reset release → value_frame = 0x00A3 after the first tick. Change value_in to 0x1234 at (100,50) → value_frame stays 0x00A3 until the frame_start edge, then 0x1234.
- Assert rst at (300,200) for 3 clks → all outputs go to reset values immediately, value_frame = 0. After release the raster resumes from (0,0) and the first tick reloads value_frame.
